// File: rtl/matrix_scan_decoder.sv
// Debounced 5x7 LED-matrix scan decoder: rebuilds full frames from a
// column-multiplexed drive and hands them out over a valid/ready port.
module matrix_scan_decoder #(
  parameter int STABLE_CYCLES  = 2,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic        clock,
  input  logic        reset_button,
  input  logic [4:0]  matrix_col,
  input  logic [6:0]  matrix_row,
  output logic [34:0] frame_out,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        frame_changed,
  output logic        scan_error,
  output logic        frame_overrun
);

  localparam logic [3:0] STABLE  = 4'(STABLE_CYCLES);
  localparam logic [0:0] SYNC    = 1'b0;
  localparam logic [0:0] CAPTURE = 1'b1;

  logic [4:0]  col_q, prev_col;
  logic [6:0]  row_q, prev_row;
  logic [3:0]  cnt, cnt_nxt;
  logic [0:0]  state, state_nxt;
  logic [2:0]  expected, exp_nxt, col_idx;
  logic [34:0] shadow, shadow_nxt, last_acc, last_base;
  logic        same, hit, one_hot, multi_hot, err_nxt, complete;
  logic        accept, load;

  // Input register with column polarity folded so "active" is always 1.
  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      col_q    <= '0;
      row_q    <= '0;
      prev_col <= '0;
      prev_row <= '0;
      cnt      <= '0;
    end else begin
      col_q    <= COL_ACTIVE_LOW ? ~matrix_col : matrix_col;
      row_q    <= matrix_row;
      prev_col <= col_q;
      prev_row <= row_q;
      cnt      <= cnt_nxt;
    end
  end

  // hit fires only on the cycle the count first reaches STABLE for a sample.
  always_comb begin
    same    = ({col_q, row_q} == {prev_col, prev_row});
    cnt_nxt = !same ? 4'd1 : ((cnt >= STABLE) ? STABLE : cnt + 4'd1);
    hit     = (cnt_nxt == STABLE) && !(same && (cnt == STABLE));
    one_hot   = (col_q != '0) && ((col_q & (col_q - 5'd1)) == '0);
    multi_hot = (col_q != '0) && !one_hot;
    col_idx = '0;
    for (int c = 0; c < 5; c++)
      if (col_q[c]) col_idx = 3'(c);
  end

  always_comb begin
    state_nxt  = state;
    exp_nxt    = expected;
    shadow_nxt = shadow;
    err_nxt    = 1'b0;
    complete   = 1'b0;
    if (hit && multi_hot) begin
      err_nxt    = 1'b1;
      state_nxt  = SYNC;
      shadow_nxt = '0;
    end else if (hit && one_hot) begin
      if (state == SYNC) begin
        if (col_idx == 3'd0) begin
          shadow_nxt = {28'b0, row_q};
          exp_nxt    = 3'd1;
          state_nxt  = CAPTURE;
        end
      end else if (col_idx == expected) begin
        for (int c = 0; c < 5; c++)
          if (col_idx == 3'(c)) shadow_nxt[c*7 +: 7] = row_q;
        if (col_idx == 3'd4) begin
          complete  = 1'b1;
          state_nxt = SYNC;
        end else begin
          exp_nxt = expected + 3'd1;
        end
      end else begin
        err_nxt = 1'b1;
        if (col_idx == 3'd0) begin
          shadow_nxt = {28'b0, row_q};
          exp_nxt    = 3'd1;
        end else begin
          shadow_nxt = '0;
          state_nxt  = SYNC;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      state      <= SYNC;
      expected   <= '0;
      shadow     <= '0;
      scan_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      expected   <= exp_nxt;
      shadow     <= shadow_nxt;
      scan_error <= err_nxt;
    end
  end

  // A frame accepted this same cycle becomes the reference for the next one.
  always_comb begin
    accept    = frame_valid && frame_ready;
    load      = complete && (!frame_valid || frame_ready);
    last_base = accept ? frame_out : last_acc;
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      frame_out     <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      frame_overrun <= 1'b0;
      last_acc      <= '0;
    end else begin
      if (accept) last_acc <= frame_out;
      if (load) begin
        frame_out     <= shadow_nxt;
        frame_valid   <= 1'b1;
        frame_changed <= (shadow_nxt != last_base);
      end else if (complete) begin
        frame_overrun <= 1'b1;
      end else if (accept) begin
        frame_valid   <= 1'b0;
        frame_changed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Directed scans of the matrix decoder; expected frames are queued at issue
// time and popped by a monitor whenever a frame is handed over.
module tb_matrix_scan_decoder;

  typedef struct packed {
    logic [34:0] frame;
    logic        changed;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_button = 1'b0;
  logic [4:0]  matrix_col = '0;
  logic [6:0]  matrix_row = '0;
  logic        frame_ready = 1'b1;
  logic [34:0] frame_out;
  logic        frame_valid, frame_changed, scan_error, frame_overrun;

  exp_t q[$];
  int checks = 0, errors = 0, err_pulses = 0, cyc = 0, c4_cyc = 0;
  bit lat_armed = 1'b0, hold_act = 1'b0;
  logic [34:0] held;
  logic        held_chg;

  matrix_scan_decoder #(.STABLE_CYCLES(2), .COL_ACTIVE_LOW(1'b0)) dut (
    .clock(clock), .reset_button(reset_button),
    .matrix_col(matrix_col), .matrix_row(matrix_row),
    .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_changed(frame_changed),
    .scan_error(scan_error), .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability.
  always @(negedge clock) begin
    if (!reset_button) hold_act = 1'b0;
    else begin
      if (scan_error) err_pulses++;
      if (frame_valid) begin
        if (lat_armed) begin
          check("latency", 64'(cyc - c4_cyc), 64'd3);
          lat_armed = 1'b0;
        end
        if (hold_act) begin
          check("hold_frame", 64'(frame_out), 64'(held));
          check("hold_changed", 64'(frame_changed), 64'(held_chg));
        end
        if (frame_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", frame_out);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("frame_out", 64'(frame_out), 64'(e.frame));
            check("frame_changed", 64'(frame_changed), 64'(e.changed));
          end
          hold_act = 1'b0;
        end else begin
          held     = frame_out;
          held_chg = frame_changed;
          hold_act = 1'b1;
        end
      end else hold_act = 1'b0;
    end
  end

  task automatic drive(input logic [4:0] c, input logic [6:0] r, input int n, input bit arm);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      matrix_col = c;
      matrix_row = r;
      if (arm && i == 0) begin
        c4_cyc    = cyc;
        lat_armed = 1'b1;
      end
    end
  endtask

  task automatic scan(input logic [4:0][6:0] rows, input int hold, input bit arm);
    for (int c = 0; c < 5; c++)
      drive(5'(1 << c), rows[c], hold, arm && c == 4);
  endtask

  task automatic idle(input int n);
    drive(5'd0, 7'd0, n, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_frame_out"}, 64'(frame_out), 64'd0);
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
    check({tag, "_frame_changed"}, 64'(frame_changed), 64'd0);
    check({tag, "_scan_error"}, 64'(scan_error), 64'd0);
    check({tag, "_frame_overrun"}, 64'(frame_overrun), 64'd0);
  endtask

  initial begin
    logic [4:0][6:0] fa, fb, fc, fd, fe, ff, fg;
    int e0;
    fa = {7'h7F, 7'h41, 7'h41, 7'h41, 7'h7F};
    fb = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
    fc = {7'h1C, 7'h22, 7'h41, 7'h22, 7'h1C};
    fd = {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
    fe = {7'h36, 7'h49, 7'h49, 7'h7F, 7'h00};
    ff = {7'h01, 7'h01, 7'h55, 7'h2A, 7'h55};
    fg = {7'h22, 7'h41, 7'h41, 7'h41, 7'h3E};

    repeat (2) @(posedge clock);
    #1 check_zero_outputs("reset");
    reset_button = 1'b1;
    idle(2);

    // Box frame twice: first differs from zero, repeat is unchanged.
    e0 = err_pulses;
    q.push_back('{frame: 35'(fa), changed: 1'b1});
    scan(fa, 3, 1'b1);
    q.push_back('{frame: 35'(fa), changed: 1'b0});
    scan(fa, 3, 1'b0);
    idle(6);
    check("box_errors", 64'(err_pulses - e0), 64'd0);

    // Columns too short to settle: nothing at all.
    e0 = err_pulses;
    scan(fb, 1, 1'b0);
    idle(6);
    check("short_errors", 64'(err_pulses - e0), 64'd0);

    // Skipped column 2, then a clean recovery scan.
    e0 = err_pulses;
    drive(5'b00001, 7'h11, 3, 1'b0);
    drive(5'b00010, 7'h22, 3, 1'b0);
    drive(5'b01000, 7'h33, 3, 1'b0);
    idle(4);
    check("skip_error", 64'(err_pulses - e0), 64'd1);
    q.push_back('{frame: 35'(fc), changed: 1'b1});
    scan(fc, 3, 1'b0);
    idle(6);
    check("recover_errors", 64'(err_pulses - e0), 64'd1);

    // Multi-hot column held well past the stability window.
    e0 = err_pulses;
    drive(5'b00110, 7'h7F, 5, 1'b0);
    idle(4);
    check("multihot_error", 64'(err_pulses - e0), 64'd1);

    // Back-pressure: second frame dropped, first held.
    frame_ready = 1'b0;
    q.push_back('{frame: 35'(fd), changed: 1'b1});
    scan(fd, 3, 1'b0);
    scan(fe, 3, 1'b0);
    idle(3);
    check("bp_overrun", 64'(frame_overrun), 64'd1);
    check("bp_valid", 64'(frame_valid), 64'd1);
    check("bp_frame_held", 64'(frame_out), 64'(35'(fd)));
    frame_ready = 1'b1;
    idle(3);
    check("bp_valid_drop", 64'(frame_valid), 64'd0);
    check("bp_overrun_sticky", 64'(frame_overrun), 64'd1);

    // Reset mid-frame; the stray 3,4 tail must not produce a frame.
    drive(5'b00001, ff[0], 3, 1'b0);
    drive(5'b00010, ff[1], 3, 1'b0);
    drive(5'b00100, ff[2], 3, 1'b0);
    @(posedge clock);
    #1;
    reset_button = 1'b0;
    matrix_col   = '0;
    matrix_row   = '0;
    #1 check_zero_outputs("midreset");
    repeat (2) @(posedge clock);
    #1 reset_button = 1'b1;
    e0 = err_pulses;
    drive(5'b01000, 7'h0F, 3, 1'b0);
    drive(5'b10000, 7'h70, 3, 1'b0);
    q.push_back('{frame: 35'(fg), changed: 1'b1});
    scan(fg, 3, 1'b0);
    idle(6);
    check("postreset_errors", 64'(err_pulses - e0), 64'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
